vector_bias_unit: RTL
=====================

# vector_bias_unit

Streaming, lane-parallel floating-point bias adder: accepts a LENGTH-element activation vector as LENGTH/LANES beats of LANES elements, adds a per-element bias held in internal registers, and emits results through a valid/ready handshake with full backpressure. Sits between the systolic array output and the activation/store stage; replaces the fully parallel, handshake-free bias adder.

## Interface
- DATA_WIDTH, 16: element width; sign/exponent/mantissa float.
- EXP_WIDTH, 5: exponent bits; mantissa = DATA_WIDTH-1-EXP_WIDTH.
- LENGTH, 16: elements per vector; must be a multiple of LANES.
- LANES, 4: elements per beat; BEATS = LENGTH/LANES.
- ADD_LAT, 2: pipeline stages inside each lane adder (≥1).
- clk  input  1  clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- in_valid / in_ready  input/output  1  input beat handshake.
- in_x  input  LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- bias_we  input  1  bias write strobe.
- bias_addr  input  $clog2(BEATS) (min 1)  beat slot to write.
- bias_wdata  input  LANES*DATA_WIDTH  bias for that slot, same lane packing.
- out_valid / out_ready  output/input  1  output beat handshake.
- out_data  output  LANES*DATA_WIDTH  sums, same lane packing.
- out_last  output  1  high with final beat (index BEATS-1) of a vector.

## Operation
- Bias file: BEATS × LANES×DATA_WIDTH registers; written when bias_we, ignored if bias_addr ≥ BEATS.
- Beat counter: 0..BEATS-1, increments on each accepted input beat (in_valid && in_ready), wraps to 0 after BEATS-1; selects bias slot. Tag last = (count == BEATS-1) travels with the beat.
- Stage 0 registers in_x, selected bias slot, last tag; then LANES parallel adders (ADD_LAT stages); valid/last shift alongside.
- Arithmetic per lane: IEEE-style add, round toward zero; subnormal inputs and results flush to +0; exponent overflow → ±infinity (exp all ones, mantissa 0); exact zero result is +0; NaN/inf inputs not supported (result undefined but must not hang).
- Stall: stall = out_valid && !out_ready; whole pipeline holds; in_ready = !stall (combinational). Bubbles do not collapse.
- Bias write and accept in same cycle, same slot: accepted beat uses old bias; new value from next cycle.
- reset: bias file cleared to 0, counter 0, pipeline valids cleared, in-flight beats dropped.

## Timing
- Latency: beat accepted at edge t appears on out_data at edge t+1+ADD_LAT (default 3) without stall; throughput one beat/cycle.
- Reset values: out_valid 0, out_data 0, out_last 0; in_ready 1 in the first cycle after reset.
- out_data/out_last held stable while out_valid && !out_ready.
- out_data is 0 whenever out_valid is 0 is not required; only values with out_valid are checked.

## Configuration
- VECTOR_BIAS_RELU_EN defined: extra input port relu_en (1 bit); when 1, any lane result with sign bit set (including -inf) is replaced by +0 at the final stage; latency unchanged.
- Undefined: port absent, results passed through unmodified.

## Structure
- Package vbu_pkg: float field struct typedef, EXP_WIDTH/mantissa width constants, exponent-all-ones and +0 constants, flush-to-zero helper function.
- Sub-module vbu_fp_add: one lane, ADD_LAT-stage pipelined adder with enable (driven by !stall); instantiated LANES times in a generate loop.

## Test plan
- Defaults, bias slot 0 lanes = 0x4000 (2.0), beat x lanes = 0x3C00 (1.0) → out lanes 0x4200 (3.0) exactly 3 cycles after accept, out_last 0.
- Four back-to-back beats, biases 0 → out_last high only on 4th output; 5th beat reuses slot 0.
- x 0x3C00 + bias 0xBC00 → 0x0000; x 0x7BFF + bias 0x7BFF → 0x7C00.
- out_ready low for 5 cycles mid-stream → in_ready low, out_data stable, no beat lost or duplicated, order preserved.
- Bias write slot 1 in same cycle beat 1 accepted → beat 1 uses old bias, next vector's beat 1 uses new.
- With VECTOR_BIAS_RELU_EN, relu_en=1: 0x3C00 + 0xC000 → 0x0000; relu_en=0 → 0xBC00. Reset mid-stream → out_valid 0 next cycle, counter restarts at beat 0.

Source files
------------

// File: rtl/vbu_pkg.sv
// Shared float-format definitions for the vector bias unit (default 16-bit, 5-bit exponent).
// The optional ReLU output stage is enabled with the VECTOR_BIAS_RELU_EN macro.
package vbu_pkg;

    localparam int VBU_DATA_W = 16;
    localparam int VBU_EXP_W  = 5;
    localparam int VBU_MAN_W  = VBU_DATA_W - 1 - VBU_EXP_W;

    typedef struct packed {
        logic                 sign;
        logic [VBU_EXP_W-1:0] exp;
        logic [VBU_MAN_W-1:0] man;
    } vbu_fp_t;

    localparam logic [VBU_EXP_W-1:0] VBU_EXP_ONES = '1;
    localparam vbu_fp_t              VBU_POS_ZERO = '0;

    // Subnormals carry a zero exponent field and are treated as +0.
    function automatic vbu_fp_t vbu_ftz(input vbu_fp_t x);
        return (x.exp == '0) ? VBU_POS_ZERO : x;
    endfunction

endpackage

// File: rtl/vbu_fp_add.sv
// One lane of the bias adder: float add (truncating, flush-to-zero, overflow to inf)
// computed in the first stage and carried through ADD_LAT enabled pipeline registers.
module vbu_fp_add
    import vbu_pkg::*;
#(
    parameter int DATA_WIDTH = VBU_DATA_W,
    parameter int EXP_WIDTH  = VBU_EXP_W,
    parameter int ADD_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] sum_o
);

    localparam int MAN_W   = DATA_WIDTH - 1 - EXP_WIDTH;
    localparam int EXT_W   = MAN_W + 4;
    localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

    logic [DATA_WIDTH-1:0] pipe_q [ADD_LAT];

    // Three guard bits plus a sticky bit keep truncation exact after the alignment shift.
    function automatic logic [DATA_WIDTH-1:0] fp_add(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b);
        logic [EXP_WIDTH-1:0] ea, eb, e_big, e_sml;
        logic [MAN_W-1:0]     ma, mb;
        logic                 swap, s_big, s_sml;
        logic [EXT_W-1:0]     x_big, x_sml, lost, norm;
        logic [EXT_W:0]       sum;
        int                   shamt, exp_r, msb;

        ea = a[DATA_WIDTH-2 -: EXP_WIDTH];
        eb = b[DATA_WIDTH-2 -: EXP_WIDTH];
        ma = (ea == '0) ? '0 : a[MAN_W-1:0];
        mb = (eb == '0) ? '0 : b[MAN_W-1:0];

        swap  = {ea, ma} < {eb, mb};
        e_big = swap ? eb : ea;
        e_sml = swap ? ea : eb;
        s_big = swap ? b[DATA_WIDTH-1] : a[DATA_WIDTH-1];
        s_sml = swap ? a[DATA_WIDTH-1] : b[DATA_WIDTH-1];
        x_big = (e_big == '0) ? '0 : {1'b1, (swap ? mb : ma), 3'b000};
        x_sml = (e_sml == '0) ? '0 : {1'b1, (swap ? ma : mb), 3'b000};

        shamt = int'(e_big) - int'(e_sml);
        lost  = x_sml & ~({EXT_W{1'b1}} << shamt);
        x_sml = (x_sml >> shamt) | {{(EXT_W-1){1'b0}}, |lost};

        if (s_big == s_sml) sum = {1'b0, x_big} + {1'b0, x_sml};
        else                sum = {1'b0, x_big} - {1'b0, x_sml};

        exp_r = int'(e_big);
        msb   = 0;
        if (sum[EXT_W]) begin
            norm  = sum[EXT_W:1];
            exp_r = exp_r + 1;
        end else begin
            for (int i = 0; i < EXT_W; i++) begin
                if (sum[i]) msb = i;
            end
            norm  = sum[EXT_W-1:0] << (EXT_W - 1 - msb);
            exp_r = exp_r - (EXT_W - 1 - msb);
        end

        if (sum == '0 || exp_r <= 0) return '0;
        if (exp_r >= EXP_MAX)        return {s_big, {EXP_WIDTH{1'b1}}, {MAN_W{1'b0}}};
        return {s_big, EXP_WIDTH'(exp_r), norm[EXT_W-2 -: MAN_W]};
    endfunction

    always_ff @(posedge clk) begin
        if (en_i) begin
            pipe_q[0] <= fp_add(a_i, b_i);
            for (int i = 1; i < ADD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign sum_o = pipe_q[ADD_LAT-1];

endmodule

// File: rtl/vector_bias_unit.sv
// Streaming lane-parallel float bias adder with valid/ready backpressure.
// Define VECTOR_BIAS_RELU_EN to add the relu_en port and the output ReLU clamp.
module vector_bias_unit
    import vbu_pkg::*;
#(
    parameter int  DATA_WIDTH = VBU_DATA_W,
    parameter int  EXP_WIDTH  = VBU_EXP_W,
    parameter int  LENGTH     = 16,
    parameter int  LANES      = 4,
    parameter int  ADD_LAT    = 2,
    localparam int BEATS      = LENGTH / LANES,
    localparam int ADDR_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_x,
    input  logic                        bias_we,
    input  logic [ADDR_W-1:0]           bias_addr,
    input  logic [LANES*DATA_WIDTH-1:0] bias_wdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last
`ifdef VECTOR_BIAS_RELU_EN
    ,
    input  logic                        relu_en
`endif
);

    localparam int VEC_W = LANES * DATA_WIDTH;

    logic [VEC_W-1:0]  bias_q [BEATS];
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              stall, adv, accept, last_tag;

    logic              vld_p0, last_p0;
    logic [VEC_W-1:0]  x_p0, b_p0;
    logic [ADD_LAT-1:0] vld_sh_q, last_sh_q;
    logic [VEC_W-1:0]  sum_w;

    logic              out_valid_q, out_last_q;
    logic [VEC_W-1:0]  out_data_q, out_data_d;

    assign stall    = out_valid_q && !out_ready;
    assign adv      = !stall;
    assign in_ready = adv;
    assign accept   = in_valid && adv;
    assign last_tag = (int'(cnt_q) == BEATS - 1);
    assign cnt_d    = last_tag ? '0 : cnt_q + ADDR_W'(1);

    // Bias writes are independent of the stall; a same-cycle accept still reads the old slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BEATS; i++) bias_q[i] <= '0;
        end else if (bias_we && int'(bias_addr) < BEATS) begin
            bias_q[bias_addr] <= bias_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            vld_p0      <= 1'b0;
            last_p0     <= 1'b0;
            vld_sh_q    <= '0;
            last_sh_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (accept) cnt_q <= cnt_d;
            if (adv) begin
                vld_p0       <= accept;
                last_p0      <= last_tag;
                vld_sh_q[0]  <= vld_p0;
                last_sh_q[0] <= last_p0;
                for (int i = 1; i < ADD_LAT; i++) begin
                    vld_sh_q[i]  <= vld_sh_q[i-1];
                    last_sh_q[i] <= last_sh_q[i-1];
                end
                out_valid_q <= vld_sh_q[ADD_LAT-1];
                out_last_q  <= last_sh_q[ADD_LAT-1];
                out_data_q  <= out_data_d;
            end
        end
    end

    // Stage 0: capture the beat and its bias slot
    always_ff @(posedge clk) begin
        if (adv) begin
            x_p0 <= in_x;
            b_p0 <= bias_q[cnt_q];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vbu_fp_add #(
            .DATA_WIDTH (DATA_WIDTH),
            .EXP_WIDTH  (EXP_WIDTH),
            .ADD_LAT    (ADD_LAT)
        ) u_add (
            .clk   (clk),
            .en_i  (adv),
            .a_i   (x_p0[l*DATA_WIDTH +: DATA_WIDTH]),
            .b_i   (b_p0[l*DATA_WIDTH +: DATA_WIDTH]),
            .sum_o (sum_w[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Output stage: optional ReLU clamp of negative lanes
    always_comb begin
        out_data_d = sum_w;
`ifdef VECTOR_BIAS_RELU_EN
        if (relu_en) begin
            for (int l = 0; l < LANES; l++) begin
                if (sum_w[l*DATA_WIDTH + DATA_WIDTH - 1]) out_data_d[l*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
`endif
    end

    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
